// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control unit.
// The datapath side (master) drives opcode/mem_ready; the controller (slave) drives everything else.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       instr_done;
    logic       err;
    logic [3:0] state;

    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               instr_done, err, state
    );

    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               instr_done, err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R-type/addi/beq/j) with a memory-wait
// watchdog that traps into a sticky ERR state until reset.
module multicycle_ctrl #(
    parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_if.slave       bus
);

    localparam int unsigned SW = 4;

    typedef enum logic [SW-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTEXEC   = 4'd6,
        S_ALUWB    = 4'd7,
        S_ADDIEXEC = 4'd8,
        S_ADDIWB   = 4'd9,
        S_BEQ      = 4'd10,
        S_JUMP     = 4'd11,
        S_ERR      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    state_e        state_q, state_d;
    logic [SW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          mem_state;
    logic          timed_out;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timed_out = (wait_q == MEM_TIMEOUT) && !bus.mem_ready;

    // Next state; mem_ready wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
                        else if (timed_out) state_d = S_ERR;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_ERR;
            end
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
                        else if (timed_out) state_d = S_ERR;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
                        else if (timed_out) state_d = S_ERR;
            S_MEMWB:    state_d = S_FETCH;
            S_RTEXEC:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ERR:      state_d = S_ERR;
            default:    state_d = S_ERR;
        endcase
    end

    // Wait counter restarts on every state change, so entry to any wait state sees zero
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (mem_state && !bus.mem_ready && (wait_q != MEM_TIMEOUT))
            wait_d = wait_q + SW'(1);
        err_d = err_q | (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Control decode from state (and mem_ready); held at zero while reset is asserted
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.instr_done  = 1'b0;
        if (rst) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE:   bus.ALUSrcB = 2'b11;
                S_MEMADR, S_ADDIEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemtoReg   = 1'b1;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.IorD       = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_RTEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegDst     = 1'b1;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BEQ: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.instr_done  = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.err   = err_q;
    assign bus.state = SW'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of state and the full
// control vector against hand-computed constants.
module tb_multicycle_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4'd15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg ALUSrcA RegWrite RegDst
    //         PCSource[1:0] ALUOp[1:0] ALUSrcB[1:0] instr_done err
    localparam logic [17:0] V_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_00_00_01_0_0;
    localparam logic [17:0] V_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_00_00_01_0_0;
    localparam logic [17:0] V_DEC     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_11_0_0;
    localparam logic [17:0] V_MEMADR  = 18'b0_0_0_0_0_0_0_1_0_0_00_00_10_0_0;
    localparam logic [17:0] V_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] V_RTEXEC  = 18'b0_0_0_0_0_0_0_1_0_0_00_10_00_0_0;
    localparam logic [17:0] V_ALUWB   = 18'b0_0_0_0_0_0_0_0_1_1_00_00_00_1_0;
    localparam logic [17:0] V_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_BEQ     = 18'b0_1_0_0_0_0_0_1_0_0_01_01_00_1_0;
    localparam logic [17:0] V_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_10_00_00_1_0;
    localparam logic [17:0] V_ERR     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    function automatic logic [17:0] obs_vec();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.instr_done, bus.err};
    endfunction

    // Drive inputs at the falling edge, check one cycle's outputs, let the rising edge advance the FSM
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic rst_v,
                       input logic [3:0] exp_st, input logic [17:0] exp_v);
        logic [3:0]  st;
        logic [17:0] v;
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = mr;
        rst           = rst_v;
        #1;
        st = bus.state;
        v  = obs_vec();
        n_checks++;
        assert (st === exp_st) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, st, exp_st);
        end
        n_checks++;
        assert (v === exp_v) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, v, exp_v);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;

        cyc("reset", 6'h00, 1'b1, 1'b0, 4'd0, V_ZERO);

        // lw, mem_ready always high: 5 cycles
        cyc("lw_fetch",  6'h23, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("lw_dec",    6'h23, 1'b1, 1'b1, 4'd1, V_DEC);
        cyc("lw_memadr", 6'h23, 1'b1, 1'b1, 4'd2, V_MEMADR);
        cyc("lw_memrd",  6'h23, 1'b1, 1'b1, 4'd3, V_MEMRD);
        cyc("lw_memwb",  6'h23, 1'b1, 1'b1, 4'd4, V_MEMWB);

        // sw with three wait cycles in MEMWR
        cyc("sw_fetch",  6'h2B, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("sw_dec",    6'h2B, 1'b1, 1'b1, 4'd1, V_DEC);
        cyc("sw_memadr", 6'h2B, 1'b1, 1'b1, 4'd2, V_MEMADR);
        cyc("sw_wait1",  6'h2B, 1'b0, 1'b1, 4'd5, V_MEMWR_W);
        cyc("sw_wait2",  6'h2B, 1'b0, 1'b1, 4'd5, V_MEMWR_W);
        cyc("sw_wait3",  6'h2B, 1'b0, 1'b1, 4'd5, V_MEMWR_W);
        cyc("sw_done",   6'h2B, 1'b1, 1'b1, 4'd5, V_MEMWR_R);

        // R-type
        cyc("rt_fetch",  6'h00, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("rt_dec",    6'h00, 1'b1, 1'b1, 4'd1, V_DEC);
        cyc("rt_exec",   6'h3F, 1'b1, 1'b1, 4'd6, V_RTEXEC);
        cyc("rt_wb",     6'h3F, 1'b1, 1'b1, 4'd7, V_ALUWB);

        // addi
        cyc("addi_fetch", 6'h08, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("addi_dec",   6'h08, 1'b1, 1'b1, 4'd1, V_DEC);
        cyc("addi_exec",  6'h08, 1'b1, 1'b1, 4'd8, V_MEMADR);
        cyc("addi_wb",    6'h08, 1'b1, 1'b1, 4'd9, V_ADDIWB);

        // beq then j, 3 cycles each
        cyc("beq_fetch", 6'h04, 1'b1, 1'b1, 4'd0,  V_FETCH_R);
        cyc("beq_dec",   6'h04, 1'b1, 1'b1, 4'd1,  V_DEC);
        cyc("beq_exec",  6'h04, 1'b1, 1'b1, 4'd10, V_BEQ);
        cyc("j_fetch",   6'h02, 1'b1, 1'b1, 4'd0,  V_FETCH_R);
        cyc("j_dec",     6'h02, 1'b1, 1'b1, 4'd1,  V_DEC);
        cyc("j_exec",    6'h02, 1'b1, 1'b1, 4'd11, V_JUMP);

        // Illegal opcode in DECODE traps; ERR is sticky regardless of inputs
        cyc("bad_fetch", 6'h3F, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("bad_dec",   6'h3F, 1'b1, 1'b1, 4'd1, V_DEC);
        for (int i = 0; i < 20; i++)
            cyc("err_hold", 6'(i), 1'(i % 2), 1'b1, 4'd12, V_ERR);
        cyc("err_rst",   6'h00, 1'b1, 1'b0, 4'd12, V_ERR);
        cyc("post_rst",  6'h00, 1'b1, 1'b1, 4'd0,  V_FETCH_R);

        // Illegal opcode seen in MEMADR also traps
        cyc("madr_dec",  6'h23, 1'b1, 1'b1, 4'd1,  V_DEC);
        cyc("madr_bad",  6'h08, 1'b1, 1'b1, 4'd2,  V_MEMADR);
        cyc("madr_err",  6'h23, 1'b1, 1'b1, 4'd12, V_ERR);
        cyc("madr_rst",  6'h23, 1'b1, 1'b0, 4'd12, V_ERR);

        // FETCH timeout: 16 waiting cycles then ERR
        for (int i = 0; i < 16; i++)
            cyc("to_wait", 6'h00, 1'b0, 1'b1, 4'd0, V_FETCH_W);
        cyc("to_err",    6'h00, 1'b0, 1'b1, 4'd12, V_ERR);
        cyc("to_rst",    6'h00, 1'b0, 1'b0, 4'd12, V_ERR);

        // Same, but mem_ready arrives on the 16th cycle
        for (int i = 0; i < 15; i++)
            cyc("edge_wait", 6'h02, 1'b0, 1'b1, 4'd0, V_FETCH_W);
        cyc("edge_ready", 6'h02, 1'b1, 1'b1, 4'd0,  V_FETCH_R);
        cyc("edge_dec",   6'h02, 1'b1, 1'b1, 4'd1,  V_DEC);
        cyc("edge_jump",  6'h02, 1'b1, 1'b1, 4'd11, V_JUMP);

        // Reset during MEMRD: outputs drop at once, no write-back follows
        cyc("mr_fetch",  6'h23, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("mr_dec",    6'h23, 1'b1, 1'b1, 4'd1, V_DEC);
        cyc("mr_memadr", 6'h23, 1'b1, 1'b1, 4'd2, V_MEMADR);
        cyc("mr_wait",   6'h23, 1'b0, 1'b1, 4'd3, V_MEMRD);
        cyc("mr_rst",    6'h23, 1'b1, 1'b0, 4'd3, V_ZERO);
        cyc("mr_after",  6'h23, 1'b1, 1'b1, 4'd0, V_FETCH_R);
        cyc("mr_next",   6'h23, 1'b1, 1'b1, 4'd1, V_DEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
